smart_traffic_controller_n: RTL and testbench
=============================================

Name: smart_traffic_controller_n

Overview:
Parametrised successor to the four-road smart traffic controller. It serves NUM_ROADS approaches using per-road thermometer density sensors, grants green to the densest road, and bounds each green between MIN_GREEN and MAX_GREEN cycles. Yellow and all-red phases are timed, emergency (siren) roads get priority, and red-light violations are flagged per road. It sits at the intersection top level and drives the lamp drivers and the violation camera trigger.

Parameters:
NUM_ROADS, 4, number of approaches (2..8)
LEVELS, 3, density sensor bits per road (thermometer, bit0 = nearest sensor)
MIN_GREEN, 4, minimum green cycles before a demand-based yield (>=1)
MAX_GREEN, 16, maximum green cycles while another road has demand (>MIN_GREEN)
YELLOW_TIME, 2, yellow cycles (>=1)
ALL_RED_TIME, 1, all-red clearance cycles (>=1)

Ports:
clock  in  1  system clock, all state updates on its rising edge
clear  in  1  synchronous active-high reset
density  in  NUM_ROADS*LEVELS  road r sensors at [r*LEVELS +: LEVELS]
siren  in  NUM_ROADS  emergency sound sensor per road
red_cross  in  NUM_ROADS  stop-line crossing detector per road
lights  out  3*NUM_ROADS  road r lamp {R,Y,G} at [3*(NUM_ROADS-1-r) +: 3]; road 0 is the MSB group; 100=red, 010=yellow, 001=green
state  out  3  0 IDLE, 1 SELECT, 2 GREEN, 3 YELLOW, 4 ALL_RED, 5 EMERG
active_road  out  clog2(NUM_ROADS)  road currently or last served
camera  out  NUM_ROADS  registered per-road violation flag
emergency  out  1  high while state==EMERG

Behaviour:
- Reset: on a clock edge with clear=1 the block sets state=IDLE, active_road=0, phase timer=0, camera=0. lights is decoded from the registered state, so it is all-red in the next cycle. clear overrides everything. A clear during GREEN/EMERG goes straight to all-red with no yellow.
- count[r] = popcount of road r's density bits. Non-thermometer patterns are counted the same way.
- lights: a Moore decode. GREEN/EMERG: active road 001. YELLOW: active road 010. Every other road, and all roads in IDLE/SELECT/ALL_RED, show 100.
- Timer: reset to 0 on every state change; increments each cycle in GREEN, YELLOW and ALL_RED. Width is clog2(MAX_GREEN+1).
- IDLE:
  - If any siren is high: go to EMERG with active_road = lowest-index siren road.
  - Else if any count is nonzero: go to SELECT.
  - Else stay in IDLE.
- SELECT (exactly 1 cycle): active_road = argmax count, ties to the lowest index. Next state is GREEN.
- GREEN, evaluated each cycle in priority order:
  - siren[active] high: go to EMERG on the same road, no yellow.
  - Any other siren high: go to YELLOW immediately, ignoring MIN_GREEN.
  - timer >= MIN_GREEN-1 and (count[active]==0 or some other count > count[active]): go to YELLOW.
  - timer == MAX_GREEN-1 and some other count != 0: go to YELLOW.
  - Otherwise stay. With no competing demand, green holds indefinitely.
- YELLOW: exactly YELLOW_TIME cycles, then ALL_RED.
- ALL_RED: exactly ALL_RED_TIME cycles, then IDLE. A re-arbitration or siren check follows in IDLE.
- EMERG: stays while siren[active_road]=1. Sirens on other roads are ignored until the next IDLE. Goes to YELLOW when siren[active_road]=0.
- Camera: camera[r] <= red_cross[r] & (road r lamp == 100 in the current cycle). Latency 1, level not latched. Yellow or green crossings never flag.
- Simultaneous events: siren beats density in IDLE. The own-road siren beats other-road sirens in GREEN. Multiple sirens in IDLE are served lowest index first.

Test Plan:
1. Reset: clear=1 for 2 cycles with random inputs -> lights=12'b100100100100, state=0, camera=4'b0000, emergency=0.
2. Road 2 density 111, others 001 -> IDLE, SELECT, then GREEN with active_road=2 and lights=100100001100. Drop road 2 to 000 at green cycle 1 -> green lasts exactly 4 cycles. Then 2 cycles of 100100010100, 1 cycle all-red, then IDLE.
3. Tie: roads 1 and 3 both 011, others 000 -> active_road=1 and lights=100001100100.
4. Road 0 held at 111, road 1 at 001 -> road 0 green for exactly 16 cycles, then YELLOW.
5. Siren[3] pulsed during road 0 GREEN at timer=1 -> YELLOW next cycle, then 2 yellow + 1 all-red. Then EMERG with lights=100100100001 and emergency=1 while siren[3] is held. After siren[3] drops -> YELLOW.
6. red_cross[1]=1 while road 1 is red -> camera[1]=1 the following cycle. red_cross[0]=1 while road 0 is green -> camera[0]=0.

Source files
------------

// File: rtl/smart_traffic_controller_n.sv
// Density-driven N-road intersection controller: picks the densest approach,
// bounds each green, times yellow/all-red, and gives siren roads priority.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | all red, waiting for a siren or any density
// SELECT  | one cycle, latch the densest road as active_road
// GREEN   | active road green, min/max bounded by demand
// YELLOW  | active road yellow for YELLOW_TIME cycles
// ALL_RED | clearance for ALL_RED_TIME cycles, then back to IDLE
// EMERG   | active road green while its siren is held
module smart_traffic_controller_n #(
  parameter int NUM_ROADS    = 4,
  parameter int LEVELS       = 3,
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 16,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  localparam int RW = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_ROADS*LEVELS-1:0]   density,
  input  logic [NUM_ROADS-1:0]          siren,
  input  logic [NUM_ROADS-1:0]          red_cross,
  output logic [3*NUM_ROADS-1:0]        lights,
  output logic [2:0]                    state,
  output logic [RW-1:0]                 active_road,
  output logic [NUM_ROADS-1:0]          camera,
  output logic                          emergency
);

  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam int CW = $clog2(LEVELS + 1);
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALL_RED_TIME - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_GREEN   = 3'd2,
    ST_YELLOW  = 3'd3,
    ST_ALL_RED = 3'd4,
    ST_EMERG   = 3'd5
  } st_t;

  st_t                  cur_st;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        cnt [NUM_ROADS];
  logic [CW-1:0]        cnt_act;
  logic [CW-1:0]        best_cnt;
  logic [RW-1:0]        best_idx;
  logic [RW-1:0]        siren_idx;
  logic                 any_demand;
  logic                 other_siren;
  logic                 other_demand;
  logic                 other_greater;
  logic [NUM_ROADS-1:0] red_mask;

  always_comb begin
    for (int r = 0; r < NUM_ROADS; r++) begin
      cnt[r] = '0;
      for (int l = 0; l < LEVELS; l++)
        cnt[r] = cnt[r] + CW'(density[r*LEVELS + l]);
    end
    cnt_act       = cnt[active_road];
    best_cnt      = cnt[0];
    best_idx      = '0;
    siren_idx     = '0;
    any_demand    = 1'b0;
    other_siren   = 1'b0;
    other_demand  = 1'b0;
    other_greater = 1'b0;
    for (int r = 0; r < NUM_ROADS; r++) begin
      // strict compare keeps ties on the lowest index
      if (cnt[r] > best_cnt) begin
        best_cnt = cnt[r];
        best_idx = RW'(r);
      end
      any_demand = any_demand | (cnt[r] != '0);
      if (RW'(r) != active_road) begin
        other_siren   = other_siren | siren[r];
        other_demand  = other_demand | (cnt[r] != '0);
        other_greater = other_greater | (cnt[r] > cnt_act);
      end
    end
    for (int r = NUM_ROADS - 1; r >= 0; r--)
      if (siren[r]) siren_idx = RW'(r);
  end

  always_comb begin
    lights   = '0;
    red_mask = '1;
    for (int r = 0; r < NUM_ROADS; r++) begin
      lights[3*(NUM_ROADS-1-r) +: 3] = 3'b100;
      if (RW'(r) == active_road) begin
        if (cur_st == ST_GREEN || cur_st == ST_EMERG) begin
          lights[3*(NUM_ROADS-1-r) +: 3] = 3'b001;
          red_mask[r] = 1'b0;
        end else if (cur_st == ST_YELLOW) begin
          lights[3*(NUM_ROADS-1-r) +: 3] = 3'b010;
          red_mask[r] = 1'b0;
        end
      end
    end
  end

  assign state     = cur_st;
  assign emergency = (cur_st == ST_EMERG);

  always_ff @(posedge clock) begin
    if (clear) begin
      cur_st      <= ST_IDLE;
      active_road <= '0;
      timer       <= '0;
      camera      <= '0;
    end else begin
      camera <= red_cross & red_mask;
      case (cur_st)
        ST_IDLE: begin
          if (|siren) begin
            cur_st      <= ST_EMERG;
            active_road <= siren_idx;
          end else if (any_demand) begin
            cur_st <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          active_road <= best_idx;
          cur_st      <= ST_GREEN;
        end
        ST_GREEN: begin
          if (siren[active_road]) begin
            cur_st <= ST_EMERG;
            timer  <= '0;
          end else if (other_siren ||
                       (timer >= MIN_LAST && (cnt_act == '0 || other_greater)) ||
                       (timer == MAX_LAST && other_demand)) begin
            cur_st <= ST_YELLOW;
            timer  <= '0;
          end else if (timer != MAX_LAST) begin
            // saturate so a long uncontested green yields at once to new demand
            timer <= timer + TW'(1);
          end
        end
        ST_YELLOW: begin
          if (timer == YEL_LAST) begin
            cur_st <= ST_ALL_RED;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_ALL_RED: begin
          if (timer == AR_LAST) begin
            cur_st <= ST_IDLE;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_EMERG: begin
          if (!siren[active_road]) begin
            cur_st <= ST_YELLOW;
            timer  <= '0;
          end
        end
        default: begin
          cur_st <= ST_IDLE;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smart_traffic_controller_n.sv
// Scoreboard bench for smart_traffic_controller_n with default parameters:
// each step queues the expected post-edge outputs, then pops and compares them.
module tb_smart_traffic_controller_n;

  localparam int S_IDLE = 0, S_SEL = 1, S_GRN = 2, S_YEL = 3, S_AR = 4, S_EMG = 5;

  logic        clock = 1'b0;
  logic        clear;
  logic [11:0] density;
  logic [3:0]  siren;
  logic [3:0]  red_cross;
  logic [11:0] lights;
  logic [2:0]  state;
  logic [1:0]  active_road;
  logic [3:0]  camera;
  logic        emergency;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         st;
    int         act;
    logic [3:0] cam;
  } exp_t;

  exp_t sb[$];

  smart_traffic_controller_n dut (
    .clock       (clock),
    .clear       (clear),
    .density     (density),
    .siren       (siren),
    .red_cross   (red_cross),
    .lights      (lights),
    .state       (state),
    .active_road (active_road),
    .camera      (camera),
    .emergency   (emergency)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] lamps(input int st, input int act);
    logic [11:0] res;
    res = 12'b100100100100;
    if (st == S_GRN || st == S_EMG) res[3*(3-act) +: 3] = 3'b001;
    else if (st == S_YEL)           res[3*(3-act) +: 3] = 3'b010;
    return res;
  endfunction

  task automatic step(input string tag, input logic clr, input logic [11:0] dens,
                      input logic [3:0] sir, input logic [3:0] rc,
                      input int est, input int eact, input logic [3:0] ecam);
    exp_t e;
    clear = clr; density = dens; siren = sir; red_cross = rc;
    e.tag = tag; e.st = est; e.act = eact; e.cam = ecam;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".state"},  32'(state),       32'(e.st));
    chk({e.tag, ".lights"}, 32'(lights),      32'(lamps(e.st, e.act)));
    chk({e.tag, ".active"}, 32'(active_road), 32'(e.act));
    chk({e.tag, ".camera"}, 32'(camera),      32'(e.cam));
    chk({e.tag, ".emerg"},  32'(emergency),   32'(e.st == S_EMG));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d2, d2b, d3, d4, d5, d6;
    d2  = {3'b001, 3'b111, 3'b001, 3'b001};
    d2b = {3'b001, 3'b000, 3'b001, 3'b001};
    d3  = {3'b011, 3'b000, 3'b011, 3'b000};
    d4  = {3'b000, 3'b000, 3'b001, 3'b111};
    d5  = {3'b000, 3'b000, 3'b000, 3'b111};
    d6  = {3'b000, 3'b111, 3'b000, 3'b000};
    clear = 1'b1; density = '0; siren = '0; red_cross = '0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step("rst", 1'b1, 12'($urandom), 4'($urandom), 4'($urandom), S_IDLE, 0, 4'b0000);
    chk("rst.lights_lit", 32'(lights), 32'(12'b100100100100));
    step("idle0", 1'b0, '0, '0, '0, S_IDLE, 0, 4'b0000);

    // densest road, early yield when its demand drops
    step("t2_sel", 1'b0, d2, '0, '0, S_SEL, 0, 4'b0000);
    step("t2_g0",  1'b0, d2, '0, '0, S_GRN, 2, 4'b0000);
    chk("t2_g_lit", 32'(lights), 32'(12'b100100001100));
    step("t2_g1",  1'b0, d2,  '0, '0, S_GRN, 2, 4'b0000);
    step("t2_g2",  1'b0, d2b, '0, '0, S_GRN, 2, 4'b0000);
    step("t2_g3",  1'b0, d2b, '0, '0, S_GRN, 2, 4'b0000);
    step("t2_y0",  1'b0, d2b, '0, '0, S_YEL, 2, 4'b0000);
    chk("t2_y_lit", 32'(lights), 32'(12'b100100010100));
    step("t2_y1",  1'b0, '0, '0, '0, S_YEL,  2, 4'b0000);
    step("t2_ar",  1'b0, '0, '0, '0, S_AR,   2, 4'b0000);
    step("t2_idl", 1'b0, '0, '0, '0, S_IDLE, 2, 4'b0000);
    step("t2_hold",1'b0, '0, '0, '0, S_IDLE, 2, 4'b0000);

    // tie goes to the lowest index
    step("t3_sel", 1'b0, d3, '0, '0, S_SEL, 2, 4'b0000);
    step("t3_g0",  1'b0, d3, '0, '0, S_GRN, 1, 4'b0000);
    chk("t3_g_lit", 32'(lights), 32'(12'b100001100100));
    for (int k = 1; k < 4; k++)
      step("t3_g",  1'b0, '0, '0, '0, S_GRN, 1, 4'b0000);
    step("t3_y0",  1'b0, '0, '0, '0, S_YEL,  1, 4'b0000);
    step("t3_y1",  1'b0, '0, '0, '0, S_YEL,  1, 4'b0000);
    step("t3_ar",  1'b0, '0, '0, '0, S_AR,   1, 4'b0000);
    step("t3_idl", 1'b0, '0, '0, '0, S_IDLE, 1, 4'b0000);

    // max green cut-off under competing demand
    step("t4_sel", 1'b0, d4, '0, '0, S_SEL, 1, 4'b0000);
    for (int k = 0; k < 16; k++)
      step("t4_g",  1'b0, d4, '0, '0, S_GRN, 0, 4'b0000);
    step("t4_y0",  1'b0, d4, '0, '0, S_YEL,  0, 4'b0000);
    step("t4_y1",  1'b0, '0, '0, '0, S_YEL,  0, 4'b0000);
    step("t4_ar",  1'b0, '0, '0, '0, S_AR,   0, 4'b0000);
    step("t4_idl", 1'b0, '0, '0, '0, S_IDLE, 0, 4'b0000);

    // other-road siren cuts green, then emergency service
    step("t5_sel", 1'b0, d5, '0, '0, S_SEL, 0, 4'b0000);
    step("t5_g0",  1'b0, d5, '0, '0, S_GRN, 0, 4'b0000);
    step("t5_g1",  1'b0, d5, '0, '0, S_GRN, 0, 4'b0000);
    step("t5_y0",  1'b0, d5, 4'b1000, '0, S_YEL,  0, 4'b0000);
    step("t5_y1",  1'b0, d5, 4'b1000, '0, S_YEL,  0, 4'b0000);
    step("t5_ar",  1'b0, d5, 4'b1000, '0, S_AR,   0, 4'b0000);
    step("t5_idl", 1'b0, d5, 4'b1000, '0, S_IDLE, 0, 4'b0000);
    step("t5_em0", 1'b0, d5, 4'b1000, '0, S_EMG,  3, 4'b0000);
    chk("t5_em_lit", 32'(lights), 32'(12'b100100100001));
    step("t5_em1", 1'b0, d5, 4'b1010, '0, S_EMG,  3, 4'b0000);
    step("t5_em2", 1'b0, d5, 4'b1000, '0, S_EMG,  3, 4'b0000);
    step("t5_y2",  1'b0, '0, '0, '0, S_YEL,  3, 4'b0000);
    step("t5_y3",  1'b0, '0, '0, '0, S_YEL,  3, 4'b0000);
    step("t5_ar2", 1'b0, '0, '0, '0, S_AR,   3, 4'b0000);
    step("t5_idl2",1'b0, '0, '0, '0, S_IDLE, 3, 4'b0000);

    // own-road siren during green goes straight to emergency
    step("t5b_sel", 1'b0, d6, '0, '0, S_SEL, 3, 4'b0000);
    step("t5b_g0",  1'b0, d6, '0, '0, S_GRN, 2, 4'b0000);
    step("t5b_em",  1'b0, d6, 4'b0100, '0, S_EMG, 2, 4'b0000);
    step("t5b_y0",  1'b0, '0, '0, '0, S_YEL,  2, 4'b0000);
    step("t5b_y1",  1'b0, '0, '0, '0, S_YEL,  2, 4'b0000);
    step("t5b_ar",  1'b0, '0, '0, '0, S_AR,   2, 4'b0000);
    step("t5b_idl", 1'b0, '0, '0, '0, S_IDLE, 2, 4'b0000);

    // multiple sirens in idle: lowest index wins over density
    step("t5c_em",  1'b0, d4, 4'b1010, '0, S_EMG, 1, 4'b0000);
    step("t5c_y0",  1'b0, '0, '0, '0, S_YEL,  1, 4'b0000);
    step("t5c_y1",  1'b0, '0, '0, '0, S_YEL,  1, 4'b0000);
    step("t5c_ar",  1'b0, '0, '0, '0, S_AR,   1, 4'b0000);
    step("t5c_idl", 1'b0, '0, '0, '0, S_IDLE, 1, 4'b0000);

    // red-light camera, then clear during green
    step("t6_sel", 1'b0, d5, '0, '0,      S_SEL, 1, 4'b0000);
    step("t6_g0",  1'b0, d5, '0, 4'b0001, S_GRN, 0, 4'b0001);
    step("t6_g1",  1'b0, d5, '0, 4'b0011, S_GRN, 0, 4'b0010);
    step("t6_g2",  1'b0, d5, '0, '0,      S_GRN, 0, 4'b0000);
    step("t6_clr", 1'b1, d5, 4'b0010, 4'b1111, S_IDLE, 0, 4'b0000);
    step("t6_idl", 1'b0, '0, '0, '0,      S_IDLE, 0, 4'b0000);

    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
